// File: rtl/ring_counter_pkg.sv
// Shared constants and sizing helper for the parametrised ring/Johnson sequencer.
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  // Phase must cover the longer (Johnson) period of 2*width states.
  function automatic int phase_w(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/ring_pattern_decode.sv
// Classifies a ring pattern as legal for the given mode and reports its position
// in the sequence (0 when the pattern is not legal).
module ring_pattern_decode
  import ring_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_POS = 0
) (
  input  logic [WIDTH-1:0]            pattern,
  input  logic                        mode,
  output logic                        legal,
  output logic [phase_w(WIDTH)-1:0]   phase
);

  localparam int PHASE_W = phase_w(WIDTH);

  logic [WIDTH-1:0] inc_pat;
  logic [WIDTH-1:0] inc_inv;
  logic             lsb_run;
  logic             msb_run;
  int               ones;
  int               idx;
  int               ph;

  // A run of ones anchored at the LSB has no carry-free overlap with itself+1;
  // the same test on the inverted pattern catches a run anchored at the MSB.
  assign inc_pat = pattern + WIDTH'(1);
  assign inc_inv = ~pattern + WIDTH'(1);
  assign lsb_run = (inc_pat & pattern) == '0;
  assign msb_run = (inc_inv & ~pattern) == '0;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    ones  = 0;
    idx   = 0;
    ph    = 0;
    legal = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pattern[i]) begin
        ones = ones + 1;
        idx  = i;
      end
    end
    if (mode == MODE_RING) begin
      legal = (ones == 1);
      ph    = (idx >= RESET_POS) ? idx - RESET_POS : idx + WIDTH - RESET_POS;
    end else begin
      legal = lsb_run || msb_run;
      ph    = pattern[WIDTH-1] ? 2 * WIDTH - ones : ones;
    end
    phase = legal ? PHASE_W'(ph) : '0;
  end

endmodule

// File: rtl/ring_counter_param.sv
// Ring / Johnson sequencer with direction control, checked parallel load,
// self-correction from illegal states, phase index and wrap pulse.
module ring_counter_param
  import ring_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_POS = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      mode,
  input  logic                      dir,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  output logic [WIDTH-1:0]          out,
  output logic                      wrap,
  output logic                      load_err,
  output logic                      legal,
  output logic [phase_w(WIDTH)-1:0] phase
);

  localparam logic [WIDTH-1:0] RING_RP = WIDTH'(1) << RESET_POS;

  logic [WIDTH-1:0]          reset_pat;
  logic [WIDTH-1:0]          step_val;
  logic                      load_legal;
  logic [phase_w(WIDTH)-1:0] unused_load_phase;

  ring_pattern_decode #(.WIDTH(WIDTH), .RESET_POS(RESET_POS)) u_out_decode (
    .pattern (out),
    .mode    (mode),
    .legal   (legal),
    .phase   (phase)
  );

  ring_pattern_decode #(.WIDTH(WIDTH), .RESET_POS(RESET_POS)) u_load_decode (
    .pattern (load_value),
    .mode    (mode),
    .legal   (load_legal),
    .phase   (unused_load_phase)
  );

  assign reset_pat = (mode == MODE_JOHNSON) ? '0 : RING_RP;

  always_comb begin
    step_val = out;
    case ({mode, dir})
      {MODE_RING,    DIR_LEFT}:  step_val = {out[WIDTH-2:0], out[WIDTH-1]};
      {MODE_RING,    DIR_RIGHT}: step_val = {out[0], out[WIDTH-1:1]};
      {MODE_JOHNSON, DIR_LEFT}:  step_val = {out[WIDTH-2:0], ~out[WIDTH-1]};
      {MODE_JOHNSON, DIR_RIGHT}: step_val = {~out[0], out[WIDTH-1:1]};
      default:                   step_val = out;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      out      <= reset_pat;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
      if (load_legal) begin
        out      <= load_value;
        load_err <= 1'b0;
      end else begin
        out      <= reset_pat;
        load_err <= 1'b1;
      end
    end else if (enable && legal) begin
      out      <= step_val;
      wrap     <= (step_val == reset_pat);
      load_err <= 1'b0;
    end else if (enable) begin
      // Illegal for the current mode (e.g. after a mode switch): restart cleanly.
      out      <= reset_pat;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_counter_param.sv
// Directed self-checking bench for ring_counter_param: expectations are queued
// when stimulus is applied and compared once the clock edge has produced output.
module tb_ring_counter_param;

  logic       clock = 1'b0;
  logic       reset, enable, mode, dir, load;
  logic [3:0] load_value;
  logic [3:0] out;
  logic       wrap, load_err, legal;
  logic [2:0] phase;

  // Second instance with an odd width and non-zero reset position.
  logic [2:0] out2;
  logic       wrap2, load_err2, legal2;
  logic [2:0] phase2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [3:0] out;
    logic       wrap;
    logic       load_err;
    logic [2:0] phase;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  ring_counter_param #(.WIDTH(4), .RESET_POS(0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dir(dir),
    .load(load), .load_value(load_value), .out(out), .wrap(wrap),
    .load_err(load_err), .legal(legal), .phase(phase)
  );

  ring_counter_param #(.WIDTH(3), .RESET_POS(1)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .mode(1'b0), .dir(dir),
    .load(1'b0), .load_value(3'b000), .out(out2), .wrap(wrap2),
    .load_err(load_err2), .legal(legal2), .phase(phase2)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic [3:0] lv,
                       input logic e, input logic m, input logic d);
    reset = r; load = l; load_value = lv; enable = e; mode = m; dir = d;
  endtask

  // Queue the expectation, let one edge happen, then compare away from the edge.
  task automatic cycle(input string tag, input logic [3:0] e_out, input logic e_wrap,
                       input logic e_err, input logic [2:0] e_phase);
    exp_t e;
    e.tag = tag; e.out = e_out; e.wrap = e_wrap; e.load_err = e_err; e.phase = e_phase;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.tag, ".out"},      8'(out),      8'(e.out));
    check({e.tag, ".wrap"},     8'(wrap),     8'(e.wrap));
    check({e.tag, ".load_err"}, 8'(load_err), 8'(e.load_err));
    check({e.tag, ".phase"},    8'(phase),    8'(e.phase));
    check({e.tag, ".legal"},    8'(legal),    8'(1'b1));
  endtask

  task automatic check2(input string tag, input logic [2:0] e_out, input logic e_wrap,
                        input logic [2:0] e_phase);
    check({tag, ".out2"},   8'(out2),   8'(e_out));
    check({tag, ".wrap2"},  8'(wrap2),  8'(e_wrap));
    check({tag, ".phase2"}, 8'(phase2), 8'(e_phase));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ring_l [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] john_l [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                               4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [2:0] ring2_l [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] ph2_l   [4] = '{3'd1, 3'd2, 3'd0, 3'd1};

    // Reset in ring mode.
    drive(1, 0, 4'b0000, 0, 0, 0);
    cycle("reset_ring", 4'b0001, 0, 0, 3'd0);
    check2("reset_ring", 3'b010, 0, 3'd0);

    // Ring, left: full period, wrap only on return to 0001.
    drive(0, 0, 4'b0000, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("ring_left%0d", i), ring_l[i], i == 3, 0, 3'((i + 1) % 4));
      check2($sformatf("ring2_left%0d", i), ring2_l[i], i == 2, ph2_l[i]);
    end

    // Ring, right: phase decrements.
    drive(0, 0, 4'b0000, 1, 0, 1);
    cycle("ring_right0", 4'b1000, 0, 0, 3'd3);
    cycle("ring_right1", 4'b0100, 0, 0, 3'd2);

    // Hold at 0100.
    drive(0, 0, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle($sformatf("hold%0d", i), 4'b0100, 0, 0, 3'd2);

    // Mode switch to Johnson from an illegal pattern: self-correct.
    drive(0, 0, 4'b0000, 1, 1, 0);
    #1;
    check("switch_pre.legal", 8'(legal), 8'(1'b0));
    check("switch_pre.phase", 8'(phase), 8'(3'd0));
    cycle("switch_fix", 4'b0000, 0, 0, 3'd0);

    // Johnson, left: 8-state period, wrap on the 8th step.
    for (int i = 0; i < 8; i++)
      cycle($sformatf("john_left%0d", i), john_l[i], i == 7, 0, 3'((i + 1) % 8));

    // Johnson, right from zero.
    drive(0, 0, 4'b0000, 1, 1, 1);
    cycle("john_right0", 4'b1000, 0, 0, 3'd7);
    cycle("john_right1", 4'b1100, 0, 0, 3'd6);

    // Loads.
    drive(0, 1, 4'b0100, 0, 0, 0);
    cycle("load_ring_ok", 4'b0100, 0, 0, 3'd2);
    drive(0, 1, 4'b0110, 0, 0, 0);
    cycle("load_ring_bad", 4'b0001, 0, 1, 3'd0);
    drive(0, 0, 4'b0000, 0, 0, 0);
    cycle("load_err_clear", 4'b0001, 0, 0, 3'd0);
    drive(0, 1, 4'b0101, 0, 1, 0);
    cycle("load_john_bad", 4'b0000, 0, 1, 3'd0);
    drive(0, 1, 4'b0111, 1, 1, 0);
    cycle("load_beats_en", 4'b0111, 0, 0, 3'd3);

    // Reset beats load and enable mid-run.
    drive(1, 1, 4'b1111, 1, 1, 0);
    cycle("reset_mid", 4'b0000, 0, 0, 3'd0);

    // Legal pattern survives a mode switch and steps normally.
    drive(0, 1, 4'b0001, 0, 0, 0);
    cycle("load_0001", 4'b0001, 0, 0, 3'd0);
    drive(0, 0, 4'b0000, 1, 1, 0);
    #1;
    check("switch_ok_pre.legal", 8'(legal), 8'(1'b1));
    check("switch_ok_pre.phase", 8'(phase), 8'(3'd1));
    cycle("switch_step", 4'b0011, 0, 0, 3'd2);

    check("scoreboard_empty", 8'(sb.size()), 8'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
